// File: rtl/truth_table_scanner_if.sv
// Bus between the truth-table scanner and whoever owns the block under scan.
// TT_FIRST_HIT_EN adds the first-hit outputs to the bus.
interface truth_table_scanner_if #(parameter int NUM_IN = 6);
   // start is a request, taken only when the scanner is idle and abort is low;
   // busy covers the scan and done is a one-cycle completion strobe.
   // Results stay valid from done until the next accepted start.
   logic                     start;
   logic                     abort;
   logic                     y_in;
   logic [NUM_IN-1:0]        vec_out;
   logic                     busy;
   logic                     done;
   logic [NUM_IN:0]          ones_count;
   logic [(1<<NUM_IN)-1:0]   table_out;
`ifdef TT_FIRST_HIT_EN
   logic                     first_hit_valid;
   logic [NUM_IN-1:0]        first_hit_idx;

   modport master (output start, abort, y_in,
                   input  vec_out, busy, done, ones_count, table_out,
                          first_hit_valid, first_hit_idx);
   modport slave  (input  start, abort, y_in,
                   output vec_out, busy, done, ones_count, table_out,
                          first_hit_valid, first_hit_idx);
`else
   modport master (output start, abort, y_in,
                   input  vec_out, busy, done, ones_count, table_out);
   modport slave  (input  start, abort, y_in,
                   output vec_out, busy, done, ones_count, table_out);
`endif
endinterface

// File: rtl/truth_table_scanner.sv
// Walks every input vector of a NUM_IN-input combinational block and records its truth table.
// Optional feature macro: TT_FIRST_HIT_EN (reports the lowest vector with y_in=1).
module truth_table_scanner #(
   parameter int NUM_IN = 6,
   parameter int SETTLE = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   truth_table_scanner_if.slave  bus,
   output logic [1:0]            state_dbg
);
   typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, SAMPLE = 2'd2, DONE = 2'd3} state_t;

   localparam logic [3:0]        SETTLE_LAST = 4'((SETTLE > 0) ? SETTLE - 1 : 0);
   localparam logic [NUM_IN-1:0] VEC_LAST    = {NUM_IN{1'b1}};
   // With no settle time the scan bypasses WAIT entirely.
   localparam state_t            AFTER_DRIVE = (SETTLE == 0) ? SAMPLE : WAIT;

   state_t                   state;
   logic [3:0]               cnt;
   logic [NUM_IN-1:0]        vec_r;
   logic                     busy_r;
   logic                     done_r;
   logic [NUM_IN:0]          ones_r;
   logic [(1<<NUM_IN)-1:0]   tbl_r;
`ifdef TT_FIRST_HIT_EN
   logic                     fh_valid_r;
   logic [NUM_IN-1:0]        fh_idx_r;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         cnt    <= '0;
         vec_r  <= '0;
         busy_r <= 1'b0;
         done_r <= 1'b0;
         ones_r <= '0;
         tbl_r  <= '0;
`ifdef TT_FIRST_HIT_EN
         fh_valid_r <= 1'b0;
         fh_idx_r   <= '0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (bus.start && !bus.abort) begin
                  vec_r  <= '0;
                  tbl_r  <= '0;
                  ones_r <= '0;
                  busy_r <= 1'b1;
                  cnt    <= '0;
`ifdef TT_FIRST_HIT_EN
                  fh_valid_r <= 1'b0;
                  fh_idx_r   <= '0;
`endif
                  state <= AFTER_DRIVE;
               end
            end
            WAIT: begin
               if (bus.abort) begin
                  busy_r <= 1'b0;
                  state  <= IDLE;
               end else if (cnt == SETTLE_LAST) begin
                  state <= SAMPLE;
               end else begin
                  cnt <= cnt + 4'd1;
               end
            end
            SAMPLE: begin
               // An abort discards this cycle's sample; partial results stay visible.
               if (bus.abort) begin
                  busy_r <= 1'b0;
                  state  <= IDLE;
               end else begin
                  tbl_r[vec_r] <= bus.y_in;
                  ones_r       <= ones_r + {{NUM_IN{1'b0}}, bus.y_in};
`ifdef TT_FIRST_HIT_EN
                  if (bus.y_in && !fh_valid_r) begin
                     fh_valid_r <= 1'b1;
                     fh_idx_r   <= vec_r;
                  end
`endif
                  if (vec_r == VEC_LAST) begin
                     busy_r <= 1'b0;
                     done_r <= 1'b1;
                     state  <= DONE;
                  end else begin
                     vec_r <= vec_r + NUM_IN'(1);
                     cnt   <= '0;
                     state <= AFTER_DRIVE;
                  end
               end
            end
            DONE: begin
               done_r <= 1'b0;
               state  <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.vec_out    = vec_r;
   assign bus.busy       = busy_r;
   assign bus.done       = done_r;
   assign bus.ones_count = ones_r;
   assign bus.table_out  = tbl_r;
`ifdef TT_FIRST_HIT_EN
   assign bus.first_hit_valid = fh_valid_r;
   assign bus.first_hit_idx   = fh_idx_r;
`endif
   assign state_dbg = state;
endmodule

// File: tb/tb_truth_table_scanner.sv
// Bench for truth_table_scanner: default instance (SETTLE=1) plus a SETTLE=0 instance.
// Build with TT_FIRST_HIT_EN defined to also cover the first-hit outputs.
module tb_truth_table_scanner;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;
   int   n_checks = 0;
   int   n_fail = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   truth_table_scanner_if #(.NUM_IN(6)) bus ();
   truth_table_scanner_if #(.NUM_IN(6)) bus0 ();
   logic [1:0]  state_dbg, state_dbg0;
   logic [63:0] y_tbl = '0;

   assign bus.y_in  = y_tbl[bus.vec_out];
   assign bus0.y_in = 1'b1;

   truth_table_scanner #(.NUM_IN(6), .SETTLE(1)) dut  (.clk(clk), .rst(rst), .bus(bus),  .state_dbg(state_dbg));
   truth_table_scanner #(.NUM_IN(6), .SETTLE(0)) dut0 (.clk(clk), .rst(rst), .bus(bus0), .state_dbg(state_dbg0));

   // Scoreboard entry: {first_hit_idx[6], first_hit_valid, ones[7], table[64]}
   logic [77:0] exp_q[$];
   int          exp_cyc_q[$];
   logic [77:0] e_cur;
   int          c_cur;

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h (cyc %0d)", tag, got, exp, cyc);
      end
   endtask

   function automatic logic [77:0] build_exp(input logic [63:0] t);
      logic [6:0] ones;
      logic       fv;
      logic [5:0] fi;
      ones = '0; fv = 1'b0; fi = '0;
      for (int k = 63; k >= 0; k--) begin
         ones = ones + {6'd0, t[k]};
         if (t[k]) begin
            fv = 1'b1;
            fi = 6'(k);
         end
      end
      return {fi, fv, ones, t};
   endfunction

   task automatic check_result(input string tag, input logic [77:0] e);
      check({tag, "_ones"},  bus.ones_count, e[70:64]);
      check({tag, "_table"}, bus.table_out,  e[63:0]);
`ifdef TT_FIRST_HIT_EN
      check({tag, "_fh_valid"}, bus.first_hit_valid, e[71]);
      check({tag, "_fh_idx"},   bus.first_hit_idx,   e[77:72]);
`endif
   endtask

   // Output side of the scoreboard: each done pulse consumes one expected scan.
   always @(negedge clk) begin
      if (!rst && bus.done) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_done cyc=%0d", cyc);
         end else begin
            e_cur = exp_q.pop_front();
            c_cur = exp_cyc_q.pop_front();
            check("done_cycle", cyc, c_cur);
            check_result("done", e_cur);
            check("done_vec", bus.vec_out, 6'd63);
            check("done_busy", bus.busy, 1'b0);
         end
      end
   end

   // Drives a start pulse; returns at the negedge after the accept edge.
   task automatic start_scan(input logic [63:0] t, input bit expect_done, output int acc);
      @(negedge clk);
      y_tbl = t;
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      acc = cyc;
      check("busy_cycle1", bus.busy, 1'b1);
      if (expect_done) begin
         exp_q.push_back(build_exp(t));
         exp_cyc_q.push_back(acc + 128);
      end
   endtask

   task automatic wait_cyc(input int target);
      while (cyc < target) @(negedge clk);
   endtask

   task automatic drain(input int budget);
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < budget) begin
         @(negedge clk);
         n++;
      end
      if (exp_q.size() != 0) begin
         n_checks++;
         n_fail++;
         $display("FAIL drain_timeout pending=%0d", exp_q.size());
         exp_q.delete();
         exp_cyc_q.delete();
      end
      repeat (2) @(negedge clk);
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_busy"},  bus.busy, 1'b0);
      check({tag, "_done"},  bus.done, 1'b0);
      check({tag, "_vec"},   bus.vec_out, 6'd0);
      check({tag, "_ones"},  bus.ones_count, 7'd0);
      check({tag, "_table"}, bus.table_out, 64'd0);
      check({tag, "_state"}, state_dbg, 2'd0);
`ifdef TT_FIRST_HIT_EN
      check({tag, "_fh_valid"}, bus.first_hit_valid, 1'b0);
      check({tag, "_fh_idx"},   bus.first_hit_idx, 6'd0);
`endif
   endtask

   logic [63:0] tbl_xor, tbl_37, tbl_rnd, partial;
   int          acc, acc0;

   initial begin
      bus.start = 1'b0;  bus.abort = 1'b0;
      bus0.start = 1'b0; bus0.abort = 1'b0;
      for (int k = 0; k < 64; k++) begin
         tbl_xor[k] = k[0] ^ k[5];
         tbl_37[k]  = (k == 37);
      end
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      check_zero("reset");

      // y_in tied low, then A^F, then a single hit at 37, then random tables
      start_scan(64'd0, 1'b1, acc);
      drain(400);
      start_scan(tbl_xor, 1'b1, acc);
      drain(400);
      check("xor_bit1",  bus.table_out[1],  1'b1);
      check("xor_bit33", bus.table_out[33], 1'b0);
      check("xor_bit32", bus.table_out[32], 1'b1);
      start_scan(tbl_37, 1'b1, acc);
      drain(400);
      for (int r = 0; r < 2; r++) begin
         tbl_rnd = {$urandom(), $urandom()};
         start_scan(tbl_rnd, 1'b1, acc);
         drain(400);
      end

      // start together with abort in IDLE must not start a scan
      @(negedge clk);
      bus.start = 1'b1; bus.abort = 1'b1;
      @(negedge clk);
      bus.start = 1'b0; bus.abort = 1'b0;
      check("start_abort_busy",  bus.busy, 1'b0);
      check("start_abort_state", state_dbg, 2'd0);

      // abort sampled at cycle 40: vectors 0..18 recorded, vector 19 discarded
      start_scan(tbl_xor, 1'b0, acc);
      wait_cyc(acc + 39);
      bus.abort = 1'b1;
      @(negedge clk);
      bus.abort = 1'b0;
      partial = tbl_xor & ((64'd1 << 19) - 64'd1);
      check("abort_busy",  bus.busy, 1'b0);
      check("abort_state", state_dbg, 2'd0);
      check("abort_vec",   bus.vec_out, 6'd19);
      check_result("abort", build_exp(partial));
      wait_cyc(acc + 43);
      start_scan(tbl_xor, 1'b1, acc);
      wait_cyc(acc + 14);
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      check("ignored_start_busy", bus.busy, 1'b1);
      drain(400);

      // rst at cycle 50 mid-scan, then a full scan afterwards
      tbl_rnd = {$urandom(), $urandom()};
      start_scan(tbl_rnd, 1'b0, acc);
      wait_cyc(acc + 49);
      rst = 1'b1;
      @(negedge clk);
      check_zero("midscan_rst");
      rst = 1'b0;
      tbl_rnd = {$urandom(), $urandom()} | 64'h1;
      start_scan(tbl_rnd, 1'b1, acc);
      drain(400);

      // SETTLE=0 instance with y_in tied high
      @(negedge clk);
      bus0.start = 1'b1;
      @(negedge clk);
      bus0.start = 1'b0;
      acc0 = cyc;
      while (!bus0.done && cyc < acc0 + 200) @(negedge clk);
      if (!bus0.done) begin
         n_checks++;
         n_fail++;
         $display("FAIL s0_done_timeout cyc=%0d", cyc);
      end else begin
         check("s0_done_cycle", cyc, acc0 + 64);
         check("s0_ones",  bus0.ones_count, 7'd64);
         check("s0_table", bus0.table_out, {64{1'b1}});
`ifdef TT_FIRST_HIT_EN
         check("s0_fh_valid", bus0.first_hit_valid, 1'b1);
         check("s0_fh_idx",   bus0.first_hit_idx, 6'd0);
`endif
      end
      @(negedge clk);
      check("s0_done_pulse", bus0.done, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/truth_table_scanner.md
Name: truth_table_scanner

Overview:
- Sequencer for a NUM_IN-input combinational function block, such as the 6-input A..F -> Y logic cells in this codebase.
- On start, drives every input combination 0 .. 2^NUM_IN-1 onto the block and waits a settle interval before each sample.
- Samples the block's output for each vector and builds the full truth table plus a ones count.
- Sits beside the combinational block as its self-check / characterisation controller. vec_out bit 0 maps to input A, bit NUM_IN-1 to the last input.

Parameters:
- NUM_IN, 6, number of inputs of the target block; legal range 2..8.
- SETTLE, 1, idle cycles between driving a vector and sampling it; legal range 0..15.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  scan request, sampled only in IDLE.
- abort  input  1  synchronous scan cancel.
- y_in  input  1  output of the combinational block under scan.
- vec_out  output  NUM_IN  input vector driven to the block (registered).
- busy  output  1  high while a scan is in progress.
- done  output  1  one-cycle pulse when a scan completes.
- ones_count  output  NUM_IN+1  number of vectors with y_in=1.
- table_out  output  2^NUM_IN  bit k = y_in sampled for vector k.

Behaviour:
- Only one clock and one synchronous, active-high reset (rst); there is no other clocking or reset.
- Reset values: all outputs 0; state=IDLE. rst has priority over every other input, including mid-scan.
- States:
  - IDLE: busy=0.
  - WAIT: settle counter running.
  - SAMPLE: capture y_in.
  - DONE: done=1 for exactly one cycle, then IDLE.
- IDLE -> WAIT when start=1 and abort=0. In the same edge:
  - vec_out<=0, table_out<=0, ones_count<=0, busy<=1, settle counter<=0.
- WAIT stays for SETTLE cycles, then moves to SAMPLE. If SETTLE=0, the accept edge goes directly to SAMPLE.
- SAMPLE lasts one cycle:
  - table_out[vec_out]<=y_in.
  - ones_count<=ones_count+y_in.
  - If vec_out = 2^NUM_IN-1: go to DONE and set busy<=0.
  - Otherwise: vec_out<=vec_out+1, go to WAIT (or SAMPLE again if SETTLE=0).
- Per-vector cost: SETTLE+1 cycles.
- Timing: with the start-accept edge at cycle 0, done is high during cycle 1+2^NUM_IN*(SETTLE+1). Defaults give cycle 129.
- vec_out never wraps during a scan. It holds 2^NUM_IN-1 after completion until the next accepted start.
- ones_count width is NUM_IN+1, so the all-ones result 2^NUM_IN is representable with no overflow.
- Results (table_out, ones_count) hold until the next accepted start or rst.
- start while busy or in DONE: ignored, no restart.
- abort in WAIT or SAMPLE:
  - Next state IDLE and busy=0 on that edge.
  - No done pulse; a sample in that same cycle is discarded.
  - Partial table_out and ones_count are retained; vec_out holds.
- abort in IDLE or DONE: no effect, and the DONE pulse still completes. start and abort together in IDLE: abort wins and the scan is not started.

Optional Feature:
- Macro: TT_FIRST_HIT_EN.
- When defined, two extra outputs are added:
  - first_hit_valid (1 bit)
  - first_hit_idx (NUM_IN bits)
- Both clear to 0 on rst and on start accept.
- On the first SAMPLE with y_in=1 in a scan: first_hit_valid<=1 and first_hit_idx<=vec_out. Both then hold until the next start accept or rst. abort does not clear them.
- When undefined, these ports and their logic do not exist, and all other behaviour is identical.

Test Plan:
- Defaults, y_in tied 0, start pulse -> busy high from cycle 1; done high at cycle 129 only; ones_count=0; table_out=0; vec_out=63.
- y_in = vec_out[0]^vec_out[5] (compare against the block's A^F), defaults -> ones_count=32; table_out equals a bench-computed 64-bit reference, including bit 1=1, bit 33=0, bit 32=1.
- SETTLE=0, y_in=1 -> done at cycle 65; ones_count=64; table_out all ones; first_hit_idx=0 with TT_FIRST_HIT_EN.
- y_in = (vec_out==37), TT_FIRST_HIT_EN defined -> ones_count=1; only table_out[37]=1; first_hit_valid=1; first_hit_idx=37.
- Abort at cycle 40, then start at cycle 45 -> busy=0 from cycle 41; no done pulse; second scan completes at cycle 45+129; a start pulse at cycle 60 during the second scan is ignored.
- rst asserted at cycle 50 mid-scan -> all outputs 0 next cycle; state IDLE; a following start runs a full, correct scan.
